// File: rtl/bash_pkg.sv
// bash_pkg: shared types, defaults and constant text for the bash command responder
package bash_pkg;

    localparam int DEF_BUFFER_LEN = 128;
    localparam int DEF_LEN_W      = 13;

    typedef enum logic [2:0] {IDLE, READ, GAP, PARSE, WRITE, SOLVE, WAIT_ACK} state_t;
    typedef enum logic [2:0] {MSG_HELLO, MSG_HELP, MSG_UNKNOWN, MSG_ECHO, MSG_NONE} msg_id_t;

    localparam logic [39:0] KW_HELLO = "hello";
    localparam logic [39:0] KW_ECHO  = "echo ";
    localparam logic [31:0] KW_HELP  = "help";

    localparam int MSG_BYTES = 24;
    localparam int MSG_BITS  = 8 * MSG_BYTES;

    // Reorders a left-aligned string so character 0 sits in the low byte;
    // a right shift then walks the text and runs into zero padding past the end.
    function automatic logic [MSG_BITS-1:0] lsb_first(input logic [MSG_BITS-1:0] s);
        logic [MSG_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < MSG_BYTES; i++) r[8*i +: 8] = s[MSG_BITS-8-8*i +: 8];
        return r;
    endfunction

    localparam logic [MSG_BITS-1:0] TXT_HELLO   = lsb_first({"Hello, world!", 88'h0});
    localparam logic [MSG_BITS-1:0] TXT_HELP    = lsb_first({"cmds: hello echo help", 24'h0});
    localparam logic [MSG_BITS-1:0] TXT_UNKNOWN = lsb_first({"unknown command", 72'h0});

endpackage

// File: rtl/bash_msg_rom.sv
// bash_msg_rom: combinational fixed-message character lookup
// Ports: i_msg  message selector (echo/none read as empty)
//        i_idx  character index within the message
//        o_char character at i_idx, 8'h00 past the end of the message
module bash_msg_rom
    import bash_pkg::*;
#(
    parameter int IW = 8
)(
    input  msg_id_t         i_msg,
    input  logic [IW-1:0]   i_idx,
    output logic [7:0]      o_char
);

    logic [MSG_BITS-1:0] w_txt;

    always_comb begin
        w_txt  = (i_msg == MSG_HELLO)   ? TXT_HELLO :
                 (i_msg == MSG_HELP)    ? TXT_HELP :
                 (i_msg == MSG_UNKNOWN) ? TXT_UNKNOWN : '0;
        o_char = 8'(w_txt >> {i_idx, 3'b000});
    end

endmodule

// File: rtl/bash_cmd_responder.sv
// bash_cmd_responder: reads a command line, decodes it and writes back one response line
// Ports: clk, rst               clock, asynchronous active-high reset
//        out_newASCII_ready     command line available
//        out_lineLen            command length (already capped)
//        lineOut                current command character, 8'h00 at end of line
//        lineOut_nextASCII      pulse: command character taken
//        in_newASCII_ready      response character valid on lineIn
//        lineIn                 response character, 8'h00 ends the line
//        lineIn_nextASCII       pulse: lineIn consumed
//        in_solved              pulse: command finished
//        out_solved             acknowledge of in_solved
module bash_cmd_responder
    import bash_pkg::*;
#(
    parameter int BUFFER_LEN = DEF_BUFFER_LEN,
    parameter int LEN_W      = DEF_LEN_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             out_newASCII_ready,
    input  logic [LEN_W-1:0] out_lineLen,
    input  logic [7:0]       lineOut,
    output logic             lineOut_nextASCII,
    output logic             in_newASCII_ready,
    output logic [7:0]       lineIn,
    input  logic             lineIn_nextASCII,
    output logic             in_solved,
    input  logic             out_solved
);

    localparam int CW = $clog2(BUFFER_LEN + 1);
    localparam int AW = $clog2(BUFFER_LEN);
    localparam logic [CW-1:0] FULL = CW'(BUFFER_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           r_state;
    msg_id_t          r_msg;
    logic [CW-1:0]    r_wlen;
    logic [CW-1:0]    r_ridx;
    logic [7:0]       r_buf [BUFFER_LEN];
    logic             r_next;
    logic             r_ready;
    logic             r_solved;

    logic [LEN_W-1:0] w_wlen_ext;
    logic [CW-1:0]    w_n;
    logic [CW-1:0]    w_eidx;
    logic [39:0]      w_head;
    logic [7:0]       w_rom_char;
    logic [7:0]       w_char;
    logic             w_store;

    bash_msg_rom #(.IW(CW)) u_rom (
        .i_msg  (r_msg),
        .i_idx  (r_ridx),
        .o_char (w_rom_char)
    );

    always_comb begin
        w_wlen_ext = LEN_W'(r_wlen);
        // The peer's length is trusted only as an upper bound on what was stored.
        w_n        = (out_lineLen < w_wlen_ext) ? CW'(out_lineLen) : r_wlen;
        w_head     = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4]};
        w_eidx     = r_ridx + CW'(5);
        w_char     = (r_msg == MSG_ECHO) ?
                     ((w_eidx < r_wlen) ? r_buf[w_eidx[AW-1:0]] : 8'h00) : w_rom_char;
        w_store    = (r_state == READ) && out_newASCII_ready && (lineOut != 8'h00) && (r_wlen < FULL);
    end

    always_ff @(posedge clk) begin
        if (w_store) r_buf[r_wlen[AW-1:0]] <= lineOut;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_msg    <= MSG_NONE;
            r_wlen   <= '0;
            r_ridx   <= '0;
            r_next   <= 1'b0;
            r_ready  <= 1'b0;
            r_solved <= 1'b0;
        end else begin
            r_next   <= 1'b0;
            r_solved <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (out_newASCII_ready) begin
                        r_wlen  <= '0;
                        r_state <= READ;
                    end
                end
                READ: begin
                    // A dropped ready mid-line is treated as end of line.
                    if (!out_newASCII_ready || lineOut == 8'h00) begin
                        r_state <= PARSE;
                    end else begin
                        if (w_store) r_wlen <= r_wlen + ONE;
                        r_next  <= 1'b1;
                        r_state <= GAP;
                    end
                end
                GAP: r_state <= out_newASCII_ready ? READ : PARSE;
                PARSE: begin
                    r_wlen <= w_n;
                    r_ridx <= '0;
                    if (w_n == '0) begin
                        r_msg    <= MSG_NONE;
                        r_solved <= 1'b1;
                        r_state  <= SOLVE;
                    end else begin
                        r_msg   <= (w_n == CW'(5) && w_head == KW_HELLO)        ? MSG_HELLO :
                                   (w_n >= CW'(5) && w_head == KW_ECHO)         ? MSG_ECHO :
                                   (w_n == CW'(4) && w_head[39:8] == KW_HELP)   ? MSG_HELP : MSG_UNKNOWN;
                        r_ready <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (lineIn_nextASCII) begin
                        if (w_char == 8'h00) begin
                            r_ready  <= 1'b0;
                            r_solved <= 1'b1;
                            r_state  <= SOLVE;
                        end else begin
                            r_ridx <= r_ridx + ONE;
                        end
                    end
                end
                SOLVE: r_state <= WAIT_ACK;
                WAIT_ACK: begin
                    if (out_solved) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lineOut_nextASCII = r_next;
    assign in_newASCII_ready = r_ready;
    assign in_solved         = r_solved;
    assign lineIn            = r_ready ? w_char : 8'h00;

endmodule

// File: tb/tb_bash_cmd_responder.sv
// tb_bash_cmd_responder: randomized self-checking bench against a string-level response model
module tb_bash_cmd_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_newASCII_ready = 1'b0;
    logic [12:0] out_lineLen = '0;
    logic [7:0]  lineOut;
    logic        lineOut_nextASCII;
    logic        in_newASCII_ready;
    logic [7:0]  lineIn;
    logic        lineIn_nextASCII = 1'b0;
    logic        in_solved;
    logic        out_solved = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] cmd [0:255];
    int         cmd_n = 0;
    logic [7:0] exp_q [$];

    int next_cnt = 0;
    int next_base = 0;
    int ack_cnt = 0;
    int ack_base = 0;
    int solved_cnt = 0;
    bit prev_next = 1'b0;
    bit prev_solved = 1'b0;

    always #5 clk = ~clk;

    bash_cmd_responder dut (
        .clk                (clk),
        .rst                (rst),
        .out_newASCII_ready (out_newASCII_ready),
        .out_lineLen        (out_lineLen),
        .lineOut            (lineOut),
        .lineOut_nextASCII  (lineOut_nextASCII),
        .in_newASCII_ready  (in_newASCII_ready),
        .lineIn             (lineIn),
        .lineIn_nextASCII   (lineIn_nextASCII),
        .in_solved          (in_solved),
        .out_solved         (out_solved)
    );

    // Sender side: the character under the read pointer, 00 past the end.
    always_comb lineOut = (next_cnt - next_base < cmd_n) ? cmd[8'(next_cnt - next_base)] : 8'h00;

    always @(posedge clk) begin
        next_cnt <= next_cnt + int'(lineOut_nextASCII);
        ack_cnt  <= ack_cnt + int'(lineIn_nextASCII && in_newASCII_ready);
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (in_newASCII_ready)
            check((ack_cnt - ack_base < exp_q.size()) && lineIn == exp_q[ack_cnt - ack_base], "lineIn",
                  int'(lineIn), (ack_cnt - ack_base < exp_q.size()) ? int'(exp_q[ack_cnt - ack_base]) : -1);
        if (lineOut_nextASCII)
            check(!prev_next, "next_spacing", int'(prev_next), 0);
        if (in_solved) begin
            solved_cnt <= solved_cnt + 1;
            check(!in_newASCII_ready && !prev_solved, "solved_pulse", int'({in_newASCII_ready, prev_solved}), 0);
        end
        prev_next   <= lineOut_nextASCII;
        prev_solved <= in_solved;
    end

    function automatic bit starts_with(input string kw);
        for (int i = 0; i < kw.len(); i++)
            if (i >= cmd_n || cmd[i] != kw[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model();
        string r;
        int n;
        exp_q.delete();
        n = (cmd_n > 128) ? 128 : cmd_n;
        if (n == 0) return;
        if (n >= 5 && starts_with("echo ")) begin
            for (int i = 5; i < n; i++) exp_q.push_back(cmd[i]);
            exp_q.push_back(8'h00);
            return;
        end
        r = (n == 5 && starts_with("hello")) ? "Hello, world!" :
            (n == 4 && starts_with("help"))  ? "cmds: hello echo help" : "unknown command";
        for (int i = 0; i < r.len(); i++) exp_q.push_back(r[i]);
        exp_q.push_back(8'h00);
    endfunction

    task automatic set_cmd(input string s);
        cmd_n = s.len();
        for (int i = 0; i < cmd_n; i++) cmd[i] = s[i];
    endtask

    task automatic add_rand(input int extra);
        for (int i = 0; i < extra; i++) begin
            cmd[cmd_n] = 8'($urandom_range(126, 32));
            cmd_n++;
        end
    endtask

    task automatic run_cmd(input int dmin, input int dmax, input int rst_after);
        int cyc, budget, wait_cnt, base_s;
        bit done;
        model();
        @(negedge clk);
        next_base = next_cnt;
        ack_base  = ack_cnt;
        base_s    = solved_cnt;
        out_lineLen = 13'((cmd_n > 128) ? 128 : cmd_n);
        out_newASCII_ready = 1'b1;
        wait_cnt = $urandom_range(dmax, dmin);
        budget = 50 + 3 * cmd_n + (exp_q.size() + 1) * (dmax + 3);
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            lineIn_nextASCII = 1'b0;
            if (in_solved) begin
                done = 1'b1;
            end else if (rst_after >= 0 && in_newASCII_ready && ack_cnt - ack_base == rst_after) begin
                rst = 1'b1;
                #1;
                check({lineOut_nextASCII, in_newASCII_ready, in_solved, lineIn} == '0, "rst_outputs",
                      int'({lineOut_nextASCII, in_newASCII_ready, in_solved, lineIn}), 0);
                out_newASCII_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                exp_q.delete();
                return;
            end else if (in_newASCII_ready) begin
                if (wait_cnt == 0) begin
                    lineIn_nextASCII = 1'b1;
                    wait_cnt = $urandom_range(dmax, dmin);
                end else begin
                    wait_cnt--;
                end
            end
        end
        lineIn_nextASCII = 1'b0;
        check(done, "solved_timeout", cyc, budget);
        if (!done) begin
            rst = 1'b1;
            out_newASCII_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            return;
        end
        check(next_cnt - next_base == cmd_n, "next_pulses", next_cnt - next_base, cmd_n);
        check(ack_cnt - ack_base == exp_q.size(), "resp_len", ack_cnt - ack_base, exp_q.size());
        if (exp_q.size() == 0) check(cyc <= 3, "empty_latency", cyc, 3);
        out_newASCII_ready = 1'b0;
        @(negedge clk);
        out_solved = 1'b1;
        @(negedge clk);
        out_solved = 1'b0;
        check(solved_cnt - base_s == 1, "solved_count", solved_cnt - base_s, 1);
        check({lineOut_nextASCII, in_newASCII_ready, in_solved, lineIn} == '0, "idle_outputs",
              int'({lineOut_nextASCII, in_newASCII_ready, in_solved, lineIn}), 0);
        exp_q.delete();
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check({lineOut_nextASCII, in_newASCII_ready, in_solved, lineIn} == '0, "reset_outputs",
              int'({lineOut_nextASCII, in_newASCII_ready, in_solved, lineIn}), 0);
        rst = 1'b0;

        set_cmd("hello");    model();
        check(exp_q.size() == 14 && exp_q[0] == 8'h48 && exp_q[12] == 8'h21 && exp_q[13] == 8'h00,
              "model_hello", exp_q.size(), 14);
        set_cmd("echo abc"); model();
        check(exp_q.size() == 4 && exp_q[0] == 8'h61 && exp_q[2] == 8'h63 && exp_q[3] == 8'h00,
              "model_echo", exp_q.size(), 4);
        set_cmd("echo");     model();
        check(exp_q.size() == 16 && exp_q[0] == 8'h75, "model_unknown", exp_q.size(), 16);
        set_cmd("help");     model();
        check(exp_q.size() == 22 && exp_q[0] == 8'h63, "model_help", exp_q.size(), 22);
        exp_q.delete();

        set_cmd("hello");    run_cmd(0, 2, -1);
        set_cmd("echo abc"); run_cmd(50, 50, -1);
        set_cmd("");         run_cmd(0, 0, -1);
        set_cmd("foo");      run_cmd(0, 1, -1);
        set_cmd("echo");     run_cmd(0, 1, -1);
        set_cmd("hello ");   run_cmd(0, 1, -1);
        set_cmd("Hello");    run_cmd(0, 1, -1);
        set_cmd("echo ");    run_cmd(0, 1, -1);
        set_cmd("");         add_rand(130); run_cmd(0, 1, -1);
        set_cmd("echo ");    add_rand(125); run_cmd(0, 1, -1);
        set_cmd("echo x");   run_cmd(4000, 4000, -1);
        set_cmd("hello");    run_cmd(0, 3, 3);
        set_cmd("help");     run_cmd(0, 2, -1);

        for (int k = 0; k < 40; k++) begin
            t = $urandom_range(5, 0);
            case (t)
                0: begin set_cmd(""); add_rand($urandom_range(12, 0)); end
                1: begin set_cmd("echo "); add_rand($urandom_range(20, 0)); end
                2: set_cmd("hello");
                3: set_cmd("help");
                4: begin
                    set_cmd($urandom_range(1, 0) ? "hello" : "help");
                    if ($urandom_range(1, 0)) add_rand(1);
                    else cmd[$urandom_range(cmd_n - 1, 0)] = 8'($urandom_range(126, 32));
                end
                default: begin
                    set_cmd($urandom_range(1, 0) ? "echo " : "");
                    add_rand($urandom_range(135, 120) - cmd_n);
                end
            endcase
            run_cmd(0, $urandom_range(1, 0) ? 3 : 12, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
